// File: rtl/crash_course_cpu_program_counter_pkg.sv
// crash_course_cpu_pkg: shared widths, call stack depth and PC FSM state encoding
package crash_course_cpu_pkg;
  localparam int PC_W = 8;
  localparam int STACK_DEPTH = 8;
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  typedef enum logic [1:0] {RUN, HALT, FAULT} pc_state_e;
endpackage

// File: rtl/crash_course_cpu_program_counter_if.sv
// crash_course_cpu_program_counter_if: control-flow requests in, PC and call-stack strobes out
interface crash_course_cpu_program_counter_if;
  import crash_course_cpu_pkg::*;
  logic clk_en;
  logic jump_request;
  logic call_request;
  logic return_request;
  logic jump_condition_met;
  logic [PC_W-1:0] jump_target;
  logic [PC_W-1:0] return_address;
  logic halt_request;
  logic resume_request;
  logic [PC_W-1:0] program_counter_current;
  logic jump_enable;
  logic call_enable;
  logic return_enable;
  logic halted;
  logic [DEPTH_W-1:0] stack_depth;
  logic stack_fault;
  modport master (
    output clk_en, jump_request, call_request, return_request, jump_condition_met,
           jump_target, return_address, halt_request, resume_request,
    input  program_counter_current, jump_enable, call_enable, return_enable,
           halted, stack_depth, stack_fault
  );
  modport slave (
    input  clk_en, jump_request, call_request, return_request, jump_condition_met,
           jump_target, return_address, halt_request, resume_request,
    output program_counter_current, jump_enable, call_enable, return_enable,
           halted, stack_depth, stack_fault
  );
endinterface

// File: rtl/crash_course_cpu_stack_depth_counter.sv
// crash_course_cpu_stack_depth_counter: saturating call-stack occupancy with overflow/underflow flags
module crash_course_cpu_stack_depth_counter
  import crash_course_cpu_pkg::*;
(
  input  logic clk,
  input  logic sync_rst,
  input  logic en,
  input  logic inc,
  input  logic dec,
  output logic [DEPTH_W-1:0] depth,
  output logic overflow,
  output logic underflow
);
  assign overflow = inc & (depth == DEPTH_W'(STACK_DEPTH));
  assign underflow = dec & (depth == '0);
  // Count pushes and pops, pinning at full and empty
  always_ff @(posedge clk)
    if (sync_rst) depth <= '0;
    else if (en) depth <= depth + DEPTH_W'(inc & ~overflow) - DEPTH_W'(dec & ~underflow);
endmodule

// File: rtl/crash_course_cpu_program_counter.sv
// crash_course_cpu_program_counter: PC sequencer with call/return/jump, halt control; CRASH_COURSE_CPU_STACK_GUARD_EN traps stack over/underflow
module crash_course_cpu_program_counter
  import crash_course_cpu_pkg::*;
(
  input logic clk,
  input logic sync_rst,
  crash_course_cpu_program_counter_if.slave bus
);
  pc_state_e state;
  logic [PC_W-1:0] pc, next_pc;
  logic active, call_try, ret_try, jump_taken, call_en, ret_en;
  logic overflow, underflow, fault;
  assign active = bus.clk_en & ~sync_rst & (state == RUN) & ~bus.halt_request;
  assign call_try = active & bus.call_request & ~bus.return_request;
  assign ret_try = active & bus.return_request & ~bus.call_request;
  assign jump_taken = active & ~bus.call_request & ~bus.return_request & bus.jump_request & bus.jump_condition_met;
`ifdef CRASH_COURSE_CPU_STACK_GUARD_EN
  assign fault = overflow | underflow;
  assign bus.stack_fault = state == FAULT;
`else
  logic unused_flags;
  assign unused_flags = overflow | underflow;
  assign fault = 1'b0;
  assign bus.stack_fault = 1'b0;
`endif
  assign call_en = call_try & ~fault;
  assign ret_en = ret_try & ~fault;
  assign bus.call_enable = call_en;
  assign bus.return_enable = ret_en;
  assign bus.jump_enable = call_en | ret_en | jump_taken;
  assign next_pc = ret_en ? bus.return_address : (call_en | jump_taken) ? bus.jump_target : pc + PC_W'(1);
  assign bus.program_counter_current = pc;
  assign bus.halted = state == HALT;
  crash_course_cpu_stack_depth_counter u_depth (
    .clk(clk),
    .sync_rst(sync_rst),
    .en(bus.clk_en),
    .inc(call_try),
    .dec(ret_try),
    .depth(bus.stack_depth),
    .overflow(overflow),
    .underflow(underflow)
  );
  // Advance PC and execution state only on enabled cycles; fault is sticky until reset
  always_ff @(posedge clk)
    if (sync_rst) begin
      state <= RUN;
      pc <= '0;
    end else if (bus.clk_en)
      case (state)
        RUN:
          if (bus.halt_request) state <= HALT;
          else if (fault) state <= FAULT;
          else pc <= next_pc;
        HALT: if (bus.resume_request && !bus.halt_request) state <= RUN;
        default: state <= FAULT;
      endcase
endmodule

// File: tb/tb_crash_course_cpu_program_counter.sv
// tb_crash_course_cpu_program_counter: directed vector table plus hand sequences for reset, wrap and stack limits
module tb_crash_course_cpu_program_counter;
  logic clk = 1'b0;
  logic sync_rst = 1'b1;
  int nv = 0;
  int nf = 0;

  crash_course_cpu_program_counter_if bus();
  crash_course_cpu_program_counter dut (.clk(clk), .sync_rst(sync_rst), .bus(bus));

  always #5 clk = ~clk;

  // ctl = {clk_en, jump_request, jump_condition_met, call_request, return_request, halt_request, resume_request}
  // stb = {jump_enable, call_enable, return_enable}
  typedef struct {
    logic [6:0] ctl;
    logic [7:0] tgt;
    logic [7:0] ra;
    logic [2:0] stb;
    logic [7:0] pc;
    logic [3:0] dep;
    logic hlt;
  } vec_t;
  vec_t tbl[21];

  task automatic drive(input logic [6:0] ctl, input logic [7:0] tgt, input logic [7:0] ra);
    {bus.clk_en, bus.jump_request, bus.jump_condition_met, bus.call_request,
     bus.return_request, bus.halt_request, bus.resume_request} = ctl;
    bus.jump_target = tgt;
    bus.return_address = ra;
  endtask

  task automatic chk_stb(input string nm, input logic [2:0] exp);
    logic [2:0] got;
    got = {bus.jump_enable, bus.call_enable, bus.return_enable};
    nv++;
    if (got !== exp) begin
      nf++;
      $display("FAIL %s strobes got %b want %b", nm, got, exp);
    end
  endtask

  task automatic chk_st(input string nm, input logic [7:0] pc, input logic [3:0] dep, input logic hlt, input logic flt);
    nv++;
    if ({bus.program_counter_current, bus.stack_depth, bus.halted, bus.stack_fault} !== {pc, dep, hlt, flt}) begin
      nf++;
      $display("FAIL %s state got pc=%h depth=%0d halted=%b fault=%b want pc=%h depth=%0d halted=%b fault=%b",
               nm, bus.program_counter_current, bus.stack_depth, bus.halted, bus.stack_fault, pc, dep, hlt, flt);
    end
  endtask

  task automatic step(input string nm, input logic [6:0] ctl, input logic [7:0] tgt, input logic [7:0] ra,
                      input logic [2:0] stb, input logic [7:0] pc, input logic [3:0] dep, input logic hlt, input logic flt);
    drive(ctl, tgt, ra);
    #1 chk_stb(nm, stb);
    @(posedge clk);
    #1 chk_st(nm, pc, dep, hlt, flt);
  endtask

  task automatic do_rst(input string nm, input logic en);
    sync_rst = 1'b1;
    drive({en, 6'b111100}, 8'h55, 8'h66);
    #1 chk_stb(nm, 3'b000);
    @(posedge clk);
    #1 sync_rst = 1'b0;
    drive(7'b1000000, 8'h00, 8'h00);
    chk_st(nm, 8'h00, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    tbl[0]  = '{7'b1110000, 8'h10, 8'h00, 3'b100, 8'h10, 4'd0, 1'b0};
    tbl[1]  = '{7'b1001000, 8'h40, 8'h00, 3'b110, 8'h40, 4'd1, 1'b0};
    tbl[2]  = '{7'b1000000, 8'h00, 8'h00, 3'b000, 8'h41, 4'd1, 1'b0};
    tbl[3]  = '{7'b1000100, 8'h00, 8'h11, 3'b101, 8'h11, 4'd0, 1'b0};
    tbl[4]  = '{7'b1100000, 8'h80, 8'h00, 3'b000, 8'h12, 4'd0, 1'b0};
    tbl[5]  = '{7'b1110000, 8'h80, 8'h00, 3'b100, 8'h80, 4'd0, 1'b0};
    tbl[6]  = '{7'b1110000, 8'h20, 8'h00, 3'b100, 8'h20, 4'd0, 1'b0};
    tbl[7]  = '{7'b1001010, 8'h40, 8'h00, 3'b000, 8'h20, 4'd0, 1'b1};
    tbl[8]  = '{7'b1001000, 8'h40, 8'h00, 3'b000, 8'h20, 4'd0, 1'b1};
    tbl[9]  = '{7'b1000011, 8'h00, 8'h00, 3'b000, 8'h20, 4'd0, 1'b1};
    tbl[10] = '{7'b1000001, 8'h00, 8'h00, 3'b000, 8'h20, 4'd0, 1'b0};
    tbl[11] = '{7'b1000000, 8'h00, 8'h00, 3'b000, 8'h21, 4'd0, 1'b0};
    tbl[12] = '{7'b1110000, 8'h05, 8'h00, 3'b100, 8'h05, 4'd0, 1'b0};
    tbl[13] = '{7'b1111100, 8'h40, 8'h33, 3'b000, 8'h06, 4'd0, 1'b0};
    tbl[14] = '{7'b0001000, 8'h40, 8'h00, 3'b000, 8'h06, 4'd0, 1'b0};
    tbl[15] = '{7'b0110000, 8'h90, 8'h00, 3'b000, 8'h06, 4'd0, 1'b0};
    tbl[16] = '{7'b1110000, 8'hFE, 8'h00, 3'b100, 8'hFE, 4'd0, 1'b0};
    tbl[17] = '{7'b1000000, 8'h00, 8'h00, 3'b000, 8'hFF, 4'd0, 1'b0};
    tbl[18] = '{7'b1000000, 8'h00, 8'h00, 3'b000, 8'h00, 4'd0, 1'b0};
    tbl[19] = '{7'b1111000, 8'h50, 8'h00, 3'b110, 8'h50, 4'd1, 1'b0};
    tbl[20] = '{7'b1110100, 8'h90, 8'h01, 3'b101, 8'h01, 4'd0, 1'b0};

    drive(7'b1000000, 8'h00, 8'h00);
    @(posedge clk);
    #1 do_rst("reset", 1'b1);

    for (int i = 0; i < 300; i++)
      step($sformatf("idle%0d", i), 7'b1000000, 8'h00, 8'h00, 3'b000, 8'(i + 1), 4'd0, 1'b0, 1'b0);

    do_rst("reset_clk_en_low", 1'b0);

    for (int i = 0; i < 21; i++)
      step($sformatf("vec%0d", i), tbl[i].ctl, tbl[i].tgt, tbl[i].ra, tbl[i].stb, tbl[i].pc, tbl[i].dep, tbl[i].hlt, 1'b0);

`ifdef CRASH_COURSE_CPU_STACK_GUARD_EN
    step("underflow_trap", 7'b1000100, 8'h00, 8'h77, 3'b000, 8'h01, 4'd0, 1'b0, 1'b1);
    step("underflow_hold", 7'b1110001, 8'h33, 8'h00, 3'b000, 8'h01, 4'd0, 1'b0, 1'b1);
`else
    step("underflow_pass", 7'b1000100, 8'h00, 8'h77, 3'b101, 8'h77, 4'd0, 1'b0, 1'b0);
`endif
    do_rst("reset_after_underflow", 1'b1);

    for (int i = 0; i < 8; i++)
      step($sformatf("nest%0d", i), 7'b1001000, 8'(8'h60 + i), 8'h00, 3'b110, 8'(8'h60 + i), 4'(i + 1), 1'b0, 1'b0);
`ifdef CRASH_COURSE_CPU_STACK_GUARD_EN
    step("overflow_trap", 7'b1001000, 8'hA0, 8'h00, 3'b000, 8'h67, 4'd8, 1'b0, 1'b0 | 1'b1);
    step("fault_hold_jump", 7'b1110000, 8'h90, 8'h00, 3'b000, 8'h67, 4'd8, 1'b0, 1'b1);
    step("fault_hold_halt", 7'b1000110, 8'h00, 8'h12, 3'b000, 8'h67, 4'd8, 1'b0, 1'b1);
`else
    step("overflow_pass", 7'b1001000, 8'hA0, 8'h00, 3'b110, 8'hA0, 4'd8, 1'b0, 1'b0);
    step("pop_after_full", 7'b1000100, 8'h00, 8'h68, 3'b101, 8'h68, 4'd7, 1'b0, 1'b0);
`endif
    do_rst("reset_after_nest", 1'b0);
    step("fetch_after_reset", 7'b1000000, 8'h00, 8'h00, 3'b000, 8'h01, 4'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
    $finish;
  end
endmodule

// File: doc/crash_course_cpu_program_counter.md
CRASH_COURSE_CPU_PROGRAM_COUNTER -- requirements
Module: crash_course_cpu_program_counter

Interface
REQ-001 SHALL have port: clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have port: sync_rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: clk_en  input  1  global advance enable; no state change when low except reset.
REQ-004 SHALL have ports: jump_request / call_request / return_request  input  1 each  decoded control-flow instruction this cycle.
REQ-005 SHALL have port: jump_condition_met  input  1  qualifies jump_request only.
REQ-006 SHALL have port: jump_target  input  8  absolute target for jump and call.
REQ-007 SHALL have port: return_address  input  8  top-of-call-stack entry.
REQ-008 SHALL have ports: halt_request / resume_request  input  1 each  execution control.
REQ-009 SHALL have port: program_counter_current  output  8  registered PC.
REQ-010 SHALL have ports: jump_enable / call_enable / return_enable  output  1 each  combinational call-stack strobes.
REQ-011 SHALL have ports: halted  output  1; stack_depth  output  4 (0..8); stack_fault  output  1.

Function
REQ-012 SHALL implement FSM states RUN, HALT, FAULT; state and all outputs advance only when clk_en=1.
REQ-013 In RUN, no halt_request: next PC priority return > call > taken jump > PC+1.
REQ-014 Return: next PC=return_address, return_enable=1, jump_enable=1, stack_depth-1.
REQ-015 Call: next PC=jump_target, call_enable=1, jump_enable=1, stack_depth+1; stack stores PC+1 itself.
REQ-016 Jump taken (jump_request && jump_condition_met): next PC=jump_target, jump_enable=1, call/return strobes 0.
REQ-017 Jump not taken: PC+1, all strobes 0.
REQ-018 PC+1 SHALL wrap 8'hFF -> 8'h00, no flag.
REQ-019 call_request && return_request same cycle: both ignored, PC+1, all strobes 0, depth unchanged.
REQ-020 Strobes SHALL be 0 whenever clk_en=0, sync_rst=1, or state is not RUN.
REQ-021 RUN + halt_request: -> HALT, PC held, requested instruction not executed, halted=1 next cycle.
REQ-022 HALT + resume_request: -> RUN, PC held that cycle; halt_request wins if both asserted.
REQ-023 FAULT SHALL hold PC, strobes 0, exit only via sync_rst.

Reset
REQ-024 sync_rst (regardless of clk_en) SHALL set PC=8'h00, state=RUN, stack_depth=0, halted=0, stack_fault=0, mid-operation included.
REQ-025 First instruction fetch SHALL be at address 0 the cycle after reset deasserts.

Configuration
REQ-026 Macro CRASH_COURSE_CPU_STACK_GUARD_EN defined: call at depth 8 or return at depth 0 SHALL go to FAULT, strobes 0, PC held, stack_fault=1 next cycle.
REQ-027 Macro undefined: overflow call proceeds, depth saturates at 8; underflow return proceeds, depth stays 0; FAULT unreachable; stack_fault tied 0.

Structure
REQ-028 Package crash_course_cpu_pkg SHALL hold PC width (8), call stack depth (8), and FSM state enum.
REQ-029 Depth tracking SHALL be sub-module crash_course_cpu_stack_depth_counter (inc/dec/reset, saturation, overflow/underflow flags).

Verification
REQ-030 Reset then 300 cycles no requests -> PC 0,1,...,FF,0,... wraps cleanly, strobes 0.
REQ-031 PC=0x10, call_request, jump_target=0x40 -> call_enable=jump_enable=1 that cycle, PC=0x40, depth=1; later return_request, return_address=0x11 -> PC=0x11, depth=0.
REQ-032 jump_request, jump_target=0x80, condition=0 -> PC+1; condition=1 -> PC=0x80, only jump_enable=1.
REQ-033 9 nested calls: guard on -> 9th gives FAULT, stack_fault=1, PC frozen until sync_rst; guard off -> depth=8, PC=target.
REQ-034 halt_request with call_request at PC=0x20 -> no strobes, PC stays 0x20, halted=1; resume -> PC 0x21 next advance.
REQ-035 call+return same cycle at PC=0x05 -> PC=0x06, strobes 0; clk_en=0 with call_request -> no change.
